// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder. One full-adder bit slice and a carry flop
// add the operands LSB-first, one bit per clock. Operands arrive over a
// valid/ready handshake, and the result leaves over a second valid/ready
// handshake. The sum, carry-out and signed overflow stay on the outputs
// until the next operand pair is accepted.

module structural_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p_s;

    assign p_s = a_i ^ b_i;
    assign s_o = p_s ^ c_i;
    assign c_o = (a_i & b_i) | (p_s & c_i);
endmodule

module serial_adder_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic             fa_s_s;
    logic             fa_c_s;

    // The single bit slice always looks at the low bits of the shift registers.
    structural_full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s_s),
        .c_o (fa_c_s)
    );

    // Next-state logic: accept in IDLE, add one bit per cycle in RUN, hand off in DONE.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = carryin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    ovf_d    = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                sum_sh_d = {fa_s_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_c_s;
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_BIT) begin
                    // carry_q is still the carry into the MSB at this point.
                    ovf_d   = carry_q ^ fa_c_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status flags are derived from the next state so they come straight from flops.
    always_comb begin
        ready_d = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
            end
            RUN: begin
                busy_d  = 1'b1;
            end
            DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output flag registers. Reset drops any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign sum       = sum_sh_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: an 8-bit instance gets hand-computed
// vectors, and a 2-bit instance is swept exhaustively against a signed/unsigned model.

module tb_serial_adder_unit;
    logic       clk;
    logic       reset_n;

    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] a, b, sum;
    logic       cin, carryout, overflow;

    logic       in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [1:0] a2, b2, sum2;
    logic       cin2, carryout2, overflow2;

    int n_asserts = 0;
    int n_fail    = 0;
    int lat;

    serial_adder_unit #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carryin   (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carryout  (carryout),
        .overflow  (overflow),
        .busy      (busy)
    );

    serial_adder_unit #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .carryin   (cin2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .carryout  (carryout2),
        .overflow  (overflow2),
        .busy      (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair for one edge, then count cycles until out_valid.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, output int latency);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency = 0;
        while (!out_valid && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic result8(input string tag, input int latency, input logic [7:0] es,
                           input logic ec, input logic eo);
        check({tag, "_latency"}, latency, 32'd8);
        check({tag, "_out_valid"}, out_valid, 32'd1);
        check({tag, "_busy"}, busy, 32'd1);
        check({tag, "_sum"}, sum, {24'd0, es});
        check({tag, "_carryout"}, carryout, {31'd0, ec});
        check({tag, "_overflow"}, overflow, {31'd0, eo});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_after"}, out_valid, 32'd0);
        check({tag, "_in_ready_after"}, in_ready, 32'd1);
        check({tag, "_sum_hold"}, sum, {24'd0, es});
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0; out_ready2 = 1'b1;

        // Reset held for three cycles, released mid-cycle.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_carryout", carryout, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        @(posedge clk); #1;

        // Basic add and latency.
        run8(8'h35, 8'h4A, 1'b0, lat);
        result8("add_35_4a", lat, 8'h7F, 1'b0, 1'b0);

        // Carry and overflow corners.
        run8(8'hFF, 8'h01, 1'b0, lat);
        result8("add_ff_01", lat, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, lat);
        result8("add_7f_01", lat, 8'h80, 1'b0, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1, lat);
        result8("add_ff_ff_c", lat, 8'hFF, 1'b1, 1'b0);

        // Backpressure: 12+34+1 = 47, held while in_valid pulses with other operands.
        run8(8'h12, 8'h34, 1'b1, lat);
        check("bp_latency", lat, 32'd8);
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 32'd1);
            check("bp_in_ready", in_ready, 32'd0);
            check("bp_sum", sum, 32'h47);
            check("bp_carryout", carryout, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", in_ready, 32'd1);
        check("bp_sum_after", sum, 32'h47);
        @(posedge clk); #1;
        check("bp_pulse_ignored_busy", busy, 32'd0);
        check("bp_pulse_ignored_ready", in_ready, 32'd1);

        // Reset in the middle of an operation.
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_in_ready", in_ready, 32'd1);
        check("midrst_sum", sum, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("midrst_no_result", out_valid, 32'd0);
        end
        run8(8'h10, 8'h20, 1'b0, lat);
        result8("add_10_20", lat, 8'h30, 1'b0, 1'b0);

        // Exhaustive 2-bit sweep, back to back with out_ready held high.
        for (int i = 0; i < 32; i++) begin
            int ai, bi, ci, s, sa, sb, ss, lat2;
            ai = (i >> 3) & 3;
            bi = (i >> 1) & 3;
            ci = i & 1;
            s  = ai + bi + ci;
            sa = (ai >= 2) ? ai - 4 : ai;
            sb = (bi >= 2) ? bi - 4 : bi;
            ss = sa + sb + ci;
            lat2 = 0;
            while (!in_ready2 && lat2 < 10) begin
                @(posedge clk); #1;
                lat2++;
            end
            check("w2_in_ready", in_ready2, 32'd1);
            a2 = 2'(ai); b2 = 2'(bi); cin2 = 1'(ci); in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat2 = 0;
            while (!out_valid2 && lat2 < 20) begin
                @(posedge clk); #1;
                lat2++;
            end
            check("w2_latency", lat2, 32'd2);
            check("w2_sum", sum2, 32'(s & 3));
            check("w2_carryout", carryout2, 32'((s >> 2) & 1));
            check("w2_overflow", overflow2, (ss > 1 || ss < -2) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
